mux_sel_sequencer: RTL and testbench



---
 rtl/mux_sel_sequencer_pkg.sv | 34 +++
 rtl/mux_sel_sequencer_if.sv | 27 ++
 rtl/mux_sel_sequencer_req_debounce.sv | 35 +++
 rtl/mux_sel_sequencer.sv | 116 +++++++++++
 tb/tb_mux_sel_sequencer.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mux_sel_sequencer_pkg.sv
// Shared types and constants for the mux select sequencer.
// Holds the 2-bit state encoding, the counter width and the state-to-select map.
package mux_sel_sequencer_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        S_A      = 2'd0,
        S_ARM    = 2'd1,
        S_B      = 2'd2,
        S_DISARM = 2'd3
    } state_t;

    typedef struct packed {
        logic sel_b1;
        logic sel_b2;
        logic busy;
    } sel_t;

    // Select pair and busy flag that each state presents to the mux.
    function automatic sel_t state_outputs(input state_t s);
        sel_t o;
        o = '0;
        case (s)
            S_A:      o = '{sel_b1: 1'b0, sel_b2: 1'b0, busy: 1'b0};
            S_ARM:    o = '{sel_b1: 1'b1, sel_b2: 1'b0, busy: 1'b1};
            S_B:      o = '{sel_b1: 1'b1, sel_b2: 1'b1, busy: 1'b0};
            S_DISARM: o = '{sel_b1: 1'b1, sel_b2: 1'b0, busy: 1'b1};
            default:  o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/mux_sel_sequencer_if.sv
// Request/select bundle between the requesting logic and the sequencer.
// master = requester (drives req_b), slave = sequencer (drives selects).
interface mux_sel_sequencer_if;

    logic       req_b;
    logic       sel_b1;
    logic       sel_b2;
    logic       busy;
    logic [7:0] switch_count;

    modport master (
        output req_b,
        input  sel_b1,
        input  sel_b2,
        input  busy,
        input  switch_count
    );

    modport slave (
        input  req_b,
        output sel_b1,
        output sel_b2,
        output busy,
        output switch_count
    );

endinterface

// File: rtl/mux_sel_sequencer_req_debounce.sv
// Level debouncer: dout follows din only after din has differed from dout
// on DEB_CYCLES consecutive rising edges; any return to dout restarts the count.
module req_debounce
    import mux_sel_sequencer_pkg::*;
#(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic areset,
    input  logic din,
    output logic dout
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [CNT_W-1:0] deb_cnt;

    // Count consecutive disagreeing samples; accept the new level on the last one.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            deb_cnt <= '0;
            dout    <= 1'b0;
        end else if (din != dout) begin
            if (deb_cnt == DEB_LAST) begin
                dout    <= din;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end else begin
            deb_cnt <= '0;
        end
    end

endmodule

// File: rtl/mux_sel_sequencer.sv
// Break-before-make sequencer for the two mux selects of the 2-to-1 source mux.
// Optional switchover counter enabled by defining MUX_SEL_SWCOUNT_EN.
//
// state    | meaning
// ---------+-----------------------------------------------
// S_A      | source a routed, both selects low
// S_ARM    | sel_b1 high, waiting ARM_CYCLES before sel_b2
// S_B      | source b routed, both selects high
// S_DISARM | sel_b2 dropped, waiting ARM_CYCLES before sel_b1
module mux_sel_sequencer
    import mux_sel_sequencer_pkg::*;
#(
    parameter int DEB_CYCLES = 4,
    parameter int ARM_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 areset,
    mux_sel_sequencer_if.slave   bus
);

    localparam logic [CNT_W-1:0] ARM_LAST = CNT_W'(ARM_CYCLES - 1);

    logic             req_db;
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] arm_cnt_q;
    logic [CNT_W-1:0] arm_cnt_d;
    sel_t             sel_q;

    req_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_req_debounce (
        .clk    (clk),
        .areset (areset),
        .din    (bus.req_b),
        .dout   (req_db)
    );

    // Next-state and phase timer; an abort or re-make wins over the timer.
    always_comb begin
        state_d   = state_q;
        arm_cnt_d = arm_cnt_q;
        case (state_q)
            S_A: begin
                if (req_db) begin
                    state_d   = S_ARM;
                    arm_cnt_d = '0;
                end
            end
            S_ARM: begin
                if (!req_db) begin
                    state_d = S_A;
                end else if (arm_cnt_q == ARM_LAST) begin
                    state_d = S_B;
                end else begin
                    arm_cnt_d = arm_cnt_q + 1'b1;
                end
            end
            S_B: begin
                if (!req_db) begin
                    state_d   = S_DISARM;
                    arm_cnt_d = '0;
                end
            end
            S_DISARM: begin
                if (req_db) begin
                    state_d = S_B;
                end else if (arm_cnt_q == ARM_LAST) begin
                    state_d = S_A;
                end else begin
                    arm_cnt_d = arm_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = S_A;
                arm_cnt_d = '0;
            end
        endcase
    end

    // State register; selects are decoded from the next state and registered
    // so the mux sees clean flop outputs rather than decode of state_q.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q   <= S_A;
            arm_cnt_q <= '0;
            sel_q     <= '0;
        end else begin
            state_q   <= state_d;
            arm_cnt_q <= arm_cnt_d;
            sel_q     <= state_outputs(state_d);
        end
    end

    assign bus.sel_b1 = sel_q.sel_b1;
    assign bus.sel_b2 = sel_q.sel_b2;
    assign bus.busy   = sel_q.busy;

`ifdef MUX_SEL_SWCOUNT_EN
    logic [7:0] switch_count_q;

    // Count completed arm phases only; aborts and re-makes from S_DISARM are excluded.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            switch_count_q <= 8'd0;
        end else if ((state_q == S_ARM) && (state_d == S_B)) begin
            switch_count_q <= switch_count_q + 8'd1;
        end
    end

    assign bus.switch_count = switch_count_q;
`else
    assign bus.switch_count = 8'd0;
`endif

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Self-checking bench: two sequencer instances (default timing and a long arm
// phase) driven by one request stream and compared against a behavioural model.
module tb_mux_sel_sequencer;

    localparam int DEB0 = 4;
    localparam int ARM0 = 2;
    localparam int DEB1 = 4;
    localparam int ARM1 = 8;

    // model phases
    localparam int P_A   = 0;
    localparam int P_UP  = 1;
    localparam int P_B   = 2;
    localparam int P_DN  = 3;

    logic clk = 1'b0;
    logic areset;

    always #5 clk = ~clk;

    mux_sel_sequencer_if bus0 ();
    mux_sel_sequencer_if bus1 ();

    mux_sel_sequencer #(.DEB_CYCLES(DEB0), .ARM_CYCLES(ARM0)) u_dut0 (
        .clk    (clk),
        .areset (areset),
        .bus    (bus0)
    );

    mux_sel_sequencer #(.DEB_CYCLES(DEB1), .ARM_CYCLES(ARM1)) u_dut1 (
        .clk    (clk),
        .areset (areset),
        .bus    (bus1)
    );

    int checks   = 0;
    int failures = 0;

    int deb_p [2] = '{DEB0, DEB1};
    int arm_p [2] = '{ARM0, ARM1};
    int m_db  [2];
    int m_run [2];
    int m_ph  [2];
    int m_el  [2];
    int m_swc [2];

    bit sel2_seen1;
    bit sel1_low_seen1;
    int swc_save;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_db[i] = 0; m_run[i] = 0; m_ph[i] = P_A; m_el[i] = 0; m_swc[i] = 0;
        end
    endtask

    // One rising edge of the reference: the phase logic sees the debounced
    // level from before the edge, then the debounced level is updated.
    task automatic model_edge(input int i, input bit r);
        case (m_ph[i])
            P_A:  if (m_db[i] == 1) begin m_ph[i] = P_UP; m_el[i] = 0; end
            P_UP: begin
                if (m_db[i] == 0) m_ph[i] = P_A;
                else begin
                    m_el[i]++;
                    if (m_el[i] == arm_p[i]) begin
                        m_ph[i]  = P_B;
                        m_swc[i] = (m_swc[i] + 1) % 256;
                    end
                end
            end
            P_B:  if (m_db[i] == 0) begin m_ph[i] = P_DN; m_el[i] = 0; end
            default: begin
                if (m_db[i] == 1) m_ph[i] = P_B;
                else begin
                    m_el[i]++;
                    if (m_el[i] == arm_p[i]) m_ph[i] = P_A;
                end
            end
        endcase
        if (int'(r) != m_db[i]) m_run[i]++; else m_run[i] = 0;
        if (m_run[i] == deb_p[i]) begin m_db[i] = int'(r); m_run[i] = 0; end
    endtask

    task automatic check_outputs(input int i);
        logic s1, s2, bz;
        logic [7:0] sc;
        logic [7:0] exp_sc;
        if (i == 0) begin s1 = bus0.sel_b1; s2 = bus0.sel_b2; bz = bus0.busy; sc = bus0.switch_count; end
        else        begin s1 = bus1.sel_b1; s2 = bus1.sel_b2; bz = bus1.busy; sc = bus1.switch_count; end
`ifdef MUX_SEL_SWCOUNT_EN
        exp_sc = 8'(m_swc[i]);
`else
        exp_sc = 8'd0;
`endif
        chk($sformatf("sel_b1[%0d]", i), {7'd0, s1}, {7'd0, m_ph[i] != P_A});
        chk($sformatf("sel_b2[%0d]", i), {7'd0, s2}, {7'd0, m_ph[i] == P_B});
        chk($sformatf("busy[%0d]", i), {7'd0, bz}, {7'd0, (m_ph[i] == P_UP) || (m_ph[i] == P_DN)});
        chk($sformatf("switch_count[%0d]", i), sc, exp_sc);
        chk($sformatf("invariant[%0d]", i), {7'd0, s2 & ~s1}, 8'd0);
    endtask

    task automatic step(input bit r);
        bus0.req_b = r;
        bus1.req_b = r;
        @(posedge clk);
        model_edge(0, r);
        model_edge(1, r);
        #1;
        check_outputs(0);
        check_outputs(1);
        if (bus1.sel_b2) sel2_seen1 = 1'b1;
        if (!bus1.sel_b1) sel1_low_seen1 = 1'b1;
    endtask

    task automatic hold(input bit r, input int n);
        for (int k = 0; k < n; k++) step(r);
    endtask

    function automatic logic [7:0] exp_count(input int v);
`ifdef MUX_SEL_SWCOUNT_EN
        return 8'(v);
`else
        return 8'(v * 0);
`endif
    endfunction

    initial begin
        bit pat [8] = '{1, 1, 1, 0, 1, 1, 1, 1};
        bus0.req_b = 1'b0;
        bus1.req_b = 1'b0;
        areset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #2 areset = 1'b0;
        #1;
        check_outputs(0);
        check_outputs(1);

        // clean switch, default timing on instance 0
        hold(0, 3);
        for (int e = 1; e <= 8; e++) begin
            step(1);
            if (e == 4) chk("clean_sel_b1_e4", {7'd0, bus0.sel_b1}, 8'd0);
            if (e == 5) begin
                chk("clean_sel_b1_e5", {7'd0, bus0.sel_b1}, 8'd1);
                chk("clean_busy_e5", {7'd0, bus0.busy}, 8'd1);
                chk("clean_sel_b2_e5", {7'd0, bus0.sel_b2}, 8'd0);
            end
            if (e == 6) chk("clean_sel_b2_e6", {7'd0, bus0.sel_b2}, 8'd0);
            if (e == 7) begin
                chk("clean_sel_b2_e7", {7'd0, bus0.sel_b2}, 8'd1);
                chk("clean_busy_e7", {7'd0, bus0.busy}, 8'd0);
                chk("clean_count", bus0.switch_count, exp_count(1));
            end
        end
        for (int e = 1; e <= 8; e++) begin
            step(0);
            if (e == 4) chk("release_sel_b2_e4", {7'd0, bus0.sel_b2}, 8'd1);
            if (e == 5) chk("release_sel_b2_e5", {7'd0, bus0.sel_b2}, 8'd0);
            if (e == 6) chk("release_sel_b1_e6", {7'd0, bus0.sel_b1}, 8'd1);
            if (e == 7) chk("release_sel_b1_e7", {7'd0, bus0.sel_b1}, 8'd0);
        end
        hold(0, 20);

        // bounce
        for (int e = 1; e <= 9; e++) begin
            step(e <= 8 ? pat[e-1] : 1'b1);
            if (e == 7) chk("bounce_req_db_e7", {7'd0, u_dut0.req_db}, 8'd0);
            if (e == 8) begin
                chk("bounce_req_db_e8", {7'd0, u_dut0.req_db}, 8'd1);
                chk("bounce_sel_b1_e8", {7'd0, bus0.sel_b1}, 8'd0);
            end
            if (e == 9) chk("bounce_sel_b1_e9", {7'd0, bus0.sel_b1}, 8'd1);
        end
        hold(1, 16);
        hold(0, 30);

        // abort on instance 1 (long arm phase)
        swc_save = m_swc[1];
        sel2_seen1 = 1'b0;
        hold(1, 5);
        chk("abort_in_arm", {7'd0, bus1.busy}, 8'd1);
        hold(0, 5);
        chk("abort_sel_b1", {7'd0, bus1.sel_b1}, 8'd0);
        hold(0, 20);
        chk("abort_sel_b2_never", {7'd0, sel2_seen1}, 8'd0);
        chk("abort_count", bus1.switch_count, exp_count(swc_save));

        // re-make on instance 1
        hold(1, 16);
        chk("remake_in_b", {7'd0, bus1.sel_b2}, 8'd1);
        swc_save = m_swc[1];
        sel1_low_seen1 = 1'b0;
        hold(0, 6);
        chk("remake_in_disarm", {7'd0, bus1.busy}, 8'd1);
        hold(1, 5);
        chk("remake_sel_b2", {7'd0, bus1.sel_b2}, 8'd1);
        chk("remake_sel_b1_held", {7'd0, sel1_low_seen1}, 8'd0);
        chk("remake_count", bus1.switch_count, exp_count(swc_save));
        hold(0, 30);

        // randomized levels and bounces
        for (int s = 0; s < 300; s++) begin
            hold(1'($urandom_range(0, 1)), int'($urandom_range(1, 14)));
        end

        // asynchronous reset while both instances sit in S_B
        hold(1, 20);
        #3 areset = 1'b1;
        #1;
        chk("rst_sel_b1_0", {7'd0, bus0.sel_b1}, 8'd0);
        chk("rst_sel_b2_0", {7'd0, bus0.sel_b2}, 8'd0);
        chk("rst_sel_b1_1", {7'd0, bus1.sel_b1}, 8'd0);
        chk("rst_sel_b2_1", {7'd0, bus1.sel_b2}, 8'd0);
        chk("rst_count_0", bus0.switch_count, 8'd0);
        chk("rst_state_0", {6'd0, u_dut0.state_q}, 8'd0);
        bus0.req_b = 1'b0;
        bus1.req_b = 1'b0;
        @(posedge clk);
        #2 areset = 1'b0;
        model_reset();
        #1;
        check_outputs(0);
        check_outputs(1);

        // 256 full switch cycles: counter must wrap back to zero
        for (int c = 0; c < 256; c++) begin
            hold(1, 16);
            hold(0, 16);
        end
        chk("wrap_count_0", bus0.switch_count, 8'd0);
        chk("wrap_count_1", bus1.switch_count, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
